uart_rx_frame: RTL and testbench

Parametrised UART receiver replacing the fixed 8-data/2-stop frame handling with configurable data width, parity mode, stop-bit count and baud divisor. Deserialises the serial `rx` line into parallel words with per-word error flags. Delivers each word through a single-entry valid/ready holding register to the consumer logic. Sits directly behind the `rx` pin, driven by the same `clk` as the bench clocking block.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sampler.sv | 80 ++++++++
 rtl/uart_rx_frame.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_rx_frame receiver.
// Optional build macro used by this block: UART_RX_MAJORITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_states;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  // Expected parity bit for up to 9 data bits (unused upper bits must be zero).
  function automatic logic exp_parity(input logic [8:0] data, input parity_e mode);
    if (mode == PAR_ODD) begin
      return ~(^data);
    end
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser, baud counter and bit sampler for uart_rx_frame.
// With UART_RX_MAJORITY_EN defined each sample is a 2-of-3 vote around mid-bit,
// decided one clk later than the single-sample build.
module uart_rx_sampler #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic restart,
  input  logic start_phase,
  output logic rx_s,
  output logic sample_stb,
  output logic sample_bit
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned Mid  = CLK_DIV / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned Decide = Mid + 1;
`else
  localparam int unsigned Decide = Mid;
`endif

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Two-flop synchroniser and baud counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

  // Counter restarts on every FSM state entry and wraps once per bit period.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || cnt_q == CntW'(CLK_DIV - 1)) begin
      cnt_d = '0;
    end
  end

  assign rx_s = sync2_q;

  // START decides at mid-bit; later states were entered just after the previous
  // decision, so a full period later lands on the same point of the next bit.
  always_comb begin
    sample_stb = start_phase ? (cnt_q == CntW'(Decide)) : (cnt_q == CntW'(CLK_DIV - 1));
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // History of the two previous rx_s values for the vote window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], sync2_q};
    end
  end

  // 2-of-3 majority over rx_s at the last three counts.
  always_comb begin
    sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync2_q) | (hist_q[0] & sync2_q);
  end
`else
  // Single sample at mid-bit.
  always_comb begin
    sample_bit = sync2_q;
  end
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: frame FSM plus single-entry valid/ready holding register.
// Optional build macro: UART_RX_MAJORITY_EN (majority-vote sampling in uart_rx_sampler).
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 16,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam parity_e     ParMode = parity_e'(PARITY_MODE[1:0]);
  localparam int unsigned BitCntW = 4;

  uart_states           state_q, state_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_pend_q, par_pend_d;
  logic                 frm_pend_q, frm_pend_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 complete;
  logic [8:0]           par_data;
  logic                 rx_s, sample_stb, sample_bit;

  uart_rx_sampler #(
    .CLK_DIV(CLK_DIV)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .restart    (state_d != state_q),
    .start_phase(state_q == START),
    .rx_s       (rx_s),
    .sample_stb (sample_stb),
    .sample_bit (sample_bit)
  );

  // Frame FSM and holding register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_pend_q   <= 1'b0;
      frm_pend_q   <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_pend_q   <= par_pend_d;
      frm_pend_q   <= frm_pend_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic: walk start, data, optional parity and stop bits.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_pend_d = par_pend_q;
    frm_pend_d = frm_pend_q;
    complete   = 1'b0;
    par_data   = '0;
    par_data[DATA_BITS-1:0] = shift_q;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (sample_stb) begin
          if (!sample_bit) begin
            state_d    = DATA;
            bit_cnt_d  = '0;
            par_pend_d = 1'b0;
            frm_pend_d = 1'b0;
          end else begin
            state_d = IDLE;  // glitch: line back high at mid-bit
          end
        end
      end
      DATA: begin
        if (sample_stb) begin
          shift_d = {sample_bit, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BitCntW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (ParMode == PAR_NONE) ? STOP : PAR;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (sample_stb) begin
          par_pend_d = (sample_bit != exp_parity(par_data, ParMode));
          state_d    = STOP;
        end
      end
      STOP: begin
        if (sample_stb) begin
          if (!sample_bit) frm_pend_d = 1'b1;
          if (bit_cnt_q == BitCntW'(STOP_BITS - 1)) begin
            complete  = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: load on completion if free or draining; otherwise drop and flag overrun.
  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    if (complete) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = shift_q;
        data_valid_d = 1'b1;
        parity_err_d = par_pend_q;
        frame_err_d  = frm_pend_d;  // includes the final stop sample
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame (CLK_DIV 16, 8 data bits, even parity, 2 stop bits).
// Honours UART_RX_MAJORITY_EN for the mid-bit glitch case.
module tb_uart_rx_frame;

  localparam int unsigned ClkDiv = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int vectors     = 0;
  int miscompares = 0;
  int valid_cycles   = 0;
  int overrun_cycles = 0;
  logic [9:0] got_q[$];

  uart_rx_frame #(
    .CLK_DIV    (ClkDiv),
    .DATA_BITS  (8),
    .PARITY_MODE(1),
    .STOP_BITS  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Observe delivered words and pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) valid_cycles++;
      if (overrun) overrun_cycles++;
      if (data_valid && data_ready) got_q.push_back({frame_err, parity_err, data_out});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame LSB first; glitch_bit selects a bit that gets a 1-clk low pulse at mid-bit.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s0,
                            input logic s1, input int glitch_bit, input int gap);
    logic [11:0] bits;
    bits = {s1, s0, pbit, d, 1'b0};
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < int'(ClkDiv); c++) begin
        rx = (i == glitch_bit && c == 8) ? 1'b0 : bits[i];
        tick();
      end
    end
    rx = 1'b1;
    repeat (gap) tick();
  endtask

  // Reference: even parity bit is XOR of the data; flags follow directly from the frame bits.
  task automatic expect_word(input string tag, input logic [7:0] d, input logic pbit,
                             input logic s0, input logic s1);
    logic [9:0] w;
    logic       pe, fe;
    pe = (pbit != (^d));
    fe = !(s0 && s1);
    check({tag, "_count"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      w = got_q.pop_front();
      check({tag, "_word"}, {22'd0, w}, {22'd0, fe, pe, d});
    end
  endtask

  initial begin
    int v0, o0;
    logic [7:0] d;
    logic pbit, s0, s1;

    rst = 1'b1;
    rx = 1'b1;
    data_ready = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {20'd0, data_valid, parity_err, frame_err, overrun, data_out}, 0);
    rst = 1'b0;
    repeat (4) tick();

    // 1: clean 0x55, one-cycle valid with ready held
    data_ready = 1'b1;
    v0 = valid_cycles;
    o0 = overrun_cycles;
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, -1, 32);
    expect_word("t1", 8'h55, 1'b0, 1'b1, 1'b1);
    check("t1_valid_len", valid_cycles - v0, 1);
    check("t1_no_overrun", overrun_cycles - o0, 0);

    // 2: parity error
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, -1, 32);
    expect_word("t2", 8'hA5, 1'b1, 1'b1, 1'b1);

    // 3: first stop bit low, then a clean repeat (flags not sticky)
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1, 32);
    expect_word("t3_bad", 8'h3C, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, -1, 32);
    expect_word("t3_good", 8'h3C, 1'b0, 1'b1, 1'b1);

    // 4: short low pulse rejected as false start
    v0 = valid_cycles;
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (40) tick();
    check("t4_no_valid", valid_cycles - v0, 0);
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, -1, 32);
    expect_word("t4", 8'h81, 1'b0, 1'b1, 1'b1);

    // 5: overrun with consumer stalled
    data_ready = 1'b0;
    o0 = overrun_cycles;
    send_frame(8'h12, 1'b0, 1'b1, 1'b1, -1, 0);
    send_frame(8'h34, 1'b1, 1'b1, 1'b1, -1, 32);
    check("t5_held_valid", {31'd0, data_valid}, 1);
    check("t5_held_data", {24'd0, data_out}, 32'h12);
    check("t5_overrun_len", overrun_cycles - o0, 1);
    check("t5_none_taken", got_q.size(), 0);
    data_ready = 1'b1;
    repeat (2) tick();
    expect_word("t5", 8'h12, 1'b0, 1'b1, 1'b1);
    check("t5_drained", {31'd0, data_valid}, 0);
    repeat (20) tick();
    check("t5_no_34", got_q.size(), 0);

    // 6: reset during 4th data bit with a word held
    data_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, -1, 32);
    check("t6_pre_valid", {31'd0, data_valid}, 1);
    d = 8'h7E;
    rx = 1'b0;
    repeat (ClkDiv) tick();
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      repeat (ClkDiv) tick();
    end
    rx = d[3];
    repeat (8) tick();
    rst = 1'b1;
    #1;
    check("t6_reset_outs", {20'd0, data_valid, parity_err, frame_err, overrun, data_out}, 0);
    rx = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    data_ready = 1'b1;
    repeat (4) tick();
    send_frame(8'h7E, 1'b0, 1'b1, 1'b1, -1, 32);
    expect_word("t6", 8'h7E, 1'b0, 1'b1, 1'b1);
    check("t6_no_stale", got_q.size(), 0);

`ifdef UART_RX_MAJORITY_EN
    // 7: 1-clk low glitch at mid-bit of data bit 0 (a 1) is voted out
    send_frame(8'hB7, 1'b0, 1'b1, 1'b1, 1, 32);
    expect_word("t7_glitch", 8'hB7, 1'b0, 1'b1, 1'b1);
`endif

    // Random frames against the reference
    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom_range(0, 255));
      pbit = (^d) ^ ($urandom_range(0, 3) == 0);
      s0   = ($urandom_range(0, 4) != 0);
      s1   = ($urandom_range(0, 4) != 0);
      send_frame(d, pbit, s0, s1, -1, 32);
      expect_word($sformatf("rand%0d", n), d, pbit, s0, s1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
